srsc_frame_ctrl: RTL and testbench

Frame-level sequencer for the scene-radiance-recovery (SRSC) datapath. It latches the per-frame atmospheric light, joins the hazy-pixel stream with the transmission stream, and issues matched beats into the fixed-latency SRSC pipeline. Because that pipeline has no stall, the block applies credit-based flow control and buffers results in an output FIFO, presenting the dehazed stream with ready/valid and frame markers. It sits between the transmission-estimation stage and the pixel writer.

---
 rtl/srsc_pkg.sv | 10 +
 rtl/srsc_obuf.sv | 40 ++++
 rtl/srsc_frame_ctrl.sv | 150 +++++++++++++++
 tb/tb_srsc_frame_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/srsc_pkg.sv
// srsc_pkg: shared types and widths for the SRSC frame controller.
package srsc_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    localparam int PIX_W   = 8;
    localparam int TRANS_W = 16;
    localparam int ENTRY_W = 3 * PIX_W + 3;
    localparam int SOF_BIT = 3 * PIX_W;
    localparam int EOL_BIT = 3 * PIX_W + 1;
    localparam int EOF_BIT = 3 * PIX_W + 2;
endpackage

// File: rtl/srsc_obuf.sv
// srsc_obuf: first-word-fall-through FIFO with occupancy count.
module srsc_obuf #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 27
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic rd_ok;

    assign rd_ok = rd_en && (count != '0);
    assign rd_data = (count != '0) ? mem[rd_ptr] : '0;

    always_ff @(posedge clk)
        if (wr_en) mem[wr_ptr] <= wr_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(wr_en) - CW'(rd_ok);
        end
    end

    assert property (@(posedge clk) disable iff (rst) !(wr_en && count == CW'(DEPTH)));
endmodule

// File: rtl/srsc_frame_ctrl.sv
// srsc_frame_ctrl: joins pixel/transmission streams into the fixed-latency SRSC
// pipeline under credit flow control and re-emits results through an output FIFO.
module srsc_frame_ctrl
    import srsc_pkg::*;
#(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512,
    parameter int PIPE_LAT   = 3,
    parameter int OBUF_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_ale_valid,
    input  logic [PIX_W-1:0]   i_A_R,
    input  logic [PIX_W-1:0]   i_A_G,
    input  logic [PIX_W-1:0]   i_A_B,
    input  logic               i_pix_valid,
    output logic               o_pix_ready,
    input  logic [PIX_W-1:0]   i_I_R,
    input  logic [PIX_W-1:0]   i_I_G,
    input  logic [PIX_W-1:0]   i_I_B,
    input  logic               i_trans_valid,
    output logic               o_trans_ready,
    input  logic [TRANS_W-1:0] i_trans,
    output logic [PIX_W-1:0]   dp_I_R,
    output logic [PIX_W-1:0]   dp_I_G,
    output logic [PIX_W-1:0]   dp_I_B,
    output logic [PIX_W-1:0]   dp_A_R,
    output logic [PIX_W-1:0]   dp_A_G,
    output logic [PIX_W-1:0]   dp_A_B,
    output logic [TRANS_W-1:0] dp_trans,
    output logic               dp_valid,
    output logic               dp_ale_valid,
    input  logic [PIX_W-1:0]   dp_J_R,
    input  logic [PIX_W-1:0]   dp_J_G,
    input  logic [PIX_W-1:0]   dp_J_B,
    input  logic               dp_o_valid,
    output logic [PIX_W-1:0]   o_J_R,
    output logic [PIX_W-1:0]   o_J_G,
    output logic [PIX_W-1:0]   o_J_B,
    output logic               o_valid,
    input  logic               i_ready,
    output logic               o_sof,
    output logic               o_eol,
    output logic               o_eof,
    output logic               o_frame_done,
    output logic               o_busy,
    output logic               o_err
);
    localparam int CRW = $clog2(OBUF_DEPTH + 1);
    localparam int CLW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int RWW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    state_t state, state_n;
    logic [CLW-1:0] col;
    logic [RWW-1:0] row;
    logic [CRW-1:0] credit, fifo_count;
    logic [PIX_W-1:0] sh_R, sh_G, sh_B;
    logic [2:0] dp_flags;
    logic [3:0] sr [PIPE_LAT];
    logic [ENTRY_W-1:0] wr_data, rd_data;
    logic pend, load, use_live, has_credit, run, fire, pop, col_end, row_end, last;

    assign run        = state == RUN;
    assign has_credit = credit != '0;
    assign fire       = run && i_pix_valid && i_trans_valid && has_credit;
    assign o_pix_ready   = run && has_credit && i_trans_valid;
    assign o_trans_ready = run && has_credit && i_pix_valid;
    assign col_end    = col == CLW'(IMG_WIDTH - 1);
    assign row_end    = row == RWW'(IMG_HEIGHT - 1);
    assign last       = col_end && row_end;
    assign use_live   = (state == IDLE) && i_ale_valid;

    assign o_valid = fifo_count != '0;
    assign pop     = o_valid && i_ready;
    assign o_J_R   = rd_data[3*PIX_W-1 -: PIX_W];
    assign o_J_G   = rd_data[2*PIX_W-1 -: PIX_W];
    assign o_J_B   = rd_data[PIX_W-1:0];
    assign o_sof   = rd_data[SOF_BIT];
    assign o_eol   = rd_data[EOL_BIT];
    assign o_eof   = rd_data[EOF_BIT];
    assign o_frame_done = (state == DRAIN) && pop && o_eof;
    assign o_busy  = state != IDLE;
    assign wr_data = {sr[PIPE_LAT-1][2:0], dp_J_R, dp_J_G, dp_J_B};

    always_comb begin
        state_n = state;
        load    = 1'b0;
        unique case (state)
            IDLE: begin
                load    = i_ale_valid || pend;
                state_n = load ? RUN : IDLE;
            end
            RUN:   state_n = (fire && last) ? DRAIN : RUN;
            DRAIN: begin
                load    = o_frame_done && pend;
                state_n = o_frame_done ? (pend ? RUN : IDLE) : DRAIN;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {dp_A_R, dp_A_G, dp_A_B, sh_R, sh_G, sh_B} <= '0;
            {dp_I_R, dp_I_G, dp_I_B, dp_trans, dp_flags} <= '0;
            {dp_valid, dp_ale_valid, pend, o_err} <= '0;
            col    <= '0;
            row    <= '0;
            credit <= CRW'(OBUF_DEPTH);
            for (int i = 0; i < PIPE_LAT; i++) sr[i] <= '0;
        end else begin
            dp_ale_valid <= load;
            if (load) {dp_A_R, dp_A_G, dp_A_B} <= use_live ? {i_A_R, i_A_G, i_A_B} : {sh_R, sh_G, sh_B};
            // A new value arriving mid-frame wins over consuming the old shadow.
            if (i_ale_valid && state != IDLE) begin
                {sh_R, sh_G, sh_B} <= {i_A_R, i_A_G, i_A_B};
                pend <= 1'b1;
            end else if (load) begin
                pend <= 1'b0;
            end
            dp_valid <= fire;
            if (fire) begin
                {dp_I_R, dp_I_G, dp_I_B, dp_trans} <= {i_I_R, i_I_G, i_I_B, i_trans};
                dp_flags <= {last, col_end, col == '0 && row == '0};
                col <= col_end ? '0 : col + 1'b1;
                if (col_end) row <= row_end ? '0 : row + 1'b1;
            end
            sr[0] <= {dp_valid, dp_flags};
            for (int i = 1; i < PIPE_LAT; i++) sr[i] <= sr[i-1];
            if (dp_o_valid != sr[PIPE_LAT-1][3]) o_err <= 1'b1;
            if (fire && !pop) credit <= credit - 1'b1;
            else if (pop && !fire) credit <= credit + 1'b1;
        end
    end

    srsc_obuf #(.DEPTH(OBUF_DEPTH), .WIDTH(ENTRY_W)) u_obuf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (dp_o_valid),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (rd_data),
        .count   (fifo_count)
    );
endmodule

// File: tb/tb_srsc_frame_ctrl.sv
// tb_srsc_frame_ctrl: randomized scoreboard bench with a behavioural SRSC stand-in.
module tb_srsc_frame_ctrl;
    localparam int W = 4;
    localparam int H = 2;
    localparam int NPIX = W * H;
    localparam int PIPE_LAT = 3;
    localparam int DEPTH = 8;

    logic clk = 0, rst;
    logic i_ale_valid, i_pix_valid, i_trans_valid, i_ready;
    logic [7:0] i_A_R, i_A_G, i_A_B, i_I_R, i_I_G, i_I_B;
    logic [15:0] i_trans, dp_trans;
    logic o_pix_ready, o_trans_ready, dp_valid, dp_ale_valid, dp_o_valid;
    logic [7:0] dp_I_R, dp_I_G, dp_I_B, dp_A_R, dp_A_G, dp_A_B, dp_J_R, dp_J_G, dp_J_B;
    logic [7:0] o_J_R, o_J_G, o_J_B;
    logic o_valid, o_sof, o_eol, o_eof, o_frame_done, o_busy, o_err;

    int checks = 0, errs = 0, cyc = 0, done_cnt = 0, frames = 0;
    int fire_cyc = -1, ov_cyc = -1;
    logic lat_arm = 0, mon_en = 1, rr_en = 0, rdy_fixed = 1, spur = 0, stall = 0;
    logic [26:0] expq [$];
    logic [26:0] held;
    logic [24:0] pipe [PIPE_LAT];

    srsc_frame_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIPE_LAT(PIPE_LAT), .OBUF_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .i_ale_valid(i_ale_valid), .i_A_R(i_A_R), .i_A_G(i_A_G), .i_A_B(i_A_B),
        .i_pix_valid(i_pix_valid), .o_pix_ready(o_pix_ready), .i_I_R(i_I_R), .i_I_G(i_I_G), .i_I_B(i_I_B),
        .i_trans_valid(i_trans_valid), .o_trans_ready(o_trans_ready), .i_trans(i_trans),
        .dp_I_R(dp_I_R), .dp_I_G(dp_I_G), .dp_I_B(dp_I_B), .dp_A_R(dp_A_R), .dp_A_G(dp_A_G), .dp_A_B(dp_A_B),
        .dp_trans(dp_trans), .dp_valid(dp_valid), .dp_ale_valid(dp_ale_valid),
        .dp_J_R(dp_J_R), .dp_J_G(dp_J_G), .dp_J_B(dp_J_B), .dp_o_valid(dp_o_valid),
        .o_J_R(o_J_R), .o_J_G(o_J_G), .o_J_B(o_J_B), .o_valid(o_valid), .i_ready(i_ready),
        .o_sof(o_sof), .o_eol(o_eol), .o_eof(o_eof), .o_frame_done(o_frame_done),
        .o_busy(o_busy), .o_err(o_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [23:0] srsc(input logic [7:0] ir, ig, ib, ar, ag, ab, input logic [15:0] t);
        return {ir ^ ar ^ t[15:8], 8'(ig + ag), 8'(ib - t[7:0])};
    endfunction

    // Stand-in for the external SRSC pipeline: fixed latency, arbitrary but known math.
    always @(posedge clk or posedge rst)
        if (rst) begin
            for (int i = 0; i < PIPE_LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= {dp_valid, srsc(dp_I_R, dp_I_G, dp_I_B, dp_A_R, dp_A_G, dp_A_B, dp_trans)};
            for (int i = 1; i < PIPE_LAT; i++) pipe[i] <= pipe[i-1];
        end
    assign dp_o_valid = pipe[PIPE_LAT-1][24] | spur;
    assign {dp_J_R, dp_J_G, dp_J_B} = pipe[PIPE_LAT-1][23:0];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    initial begin
        i_ready = 0;
        forever begin
            @(posedge clk);
            #1 i_ready = rr_en ? 1'($urandom_range(0, 1)) : rdy_fixed;
        end
    end

    always @(negedge clk) begin
        logic [26:0] cur;
        if (o_frame_done) done_cnt++;
        if (lat_arm && o_valid) begin
            ov_cyc = cyc;
            lat_arm = 0;
        end
        cur = {o_eof, o_eol, o_sof, o_J_R, o_J_G, o_J_B};
        if (mon_en && o_valid && !i_ready) begin
            if (stall) chk("hold_stable", cur, held);
            held = cur;
            stall = 1;
        end else begin
            stall = 0;
            if (mon_en && o_valid) begin
                if (expq.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL extra_output: got %h expected nothing", cur);
                end else chk("out_beat", cur, expq.pop_front());
            end
        end
    end

    task automatic rst_checks(input string nm);
        chk({nm, "_ctrl"}, {o_pix_ready, o_trans_ready, dp_valid, dp_ale_valid, o_valid, o_err,
                            o_busy, o_frame_done, o_sof, o_eol, o_eof}, 0);
        chk({nm, "_dp"}, {dp_A_R, dp_A_G, dp_A_B, dp_I_R, dp_I_G, dp_I_B, dp_trans}, 0);
        chk({nm, "_out"}, {o_J_R, o_J_G, o_J_B}, 0);
    endtask

    task automatic ale(input logic [7:0] ar, ag, ab);
        @(negedge clk);
        i_ale_valid = 1;
        {i_A_R, i_A_G, i_A_B} = {ar, ag, ab};
        @(negedge clk);
        i_ale_valid = 0;
        chk("ale_pulse", dp_ale_valid, 1);
        chk("ale_value", {dp_A_R, dp_A_G, dp_A_B}, {ar, ag, ab});
        chk("ale_busy", o_busy, 1);
    endtask

    task automatic run_frame(input logic [7:0] ar, ag, ab, input int pct, input int tdel,
                             input int ale_at, input int maxf, input int budget);
        logic [7:0] r[NPIX], g[NPIX], b[NPIX];
        logic [15:0] t[NPIX];
        logic hp, ht, pulsed;
        int pi, k;
        pi = 0; k = 0; pulsed = 0;
        for (int p = 0; p < NPIX; p++) begin
            r[p] = 8'($urandom); g[p] = 8'($urandom); b[p] = 8'($urandom); t[p] = 16'($urandom);
            expq.push_back({p == NPIX - 1, (p % W) == W - 1, p == 0, srsc(r[p], g[p], b[p], ar, ag, ab, t[p])});
        end
        while (pi < maxf && k < budget) begin
            @(negedge clk);
            i_ale_valid = (pi == ale_at) && !pulsed;
            if (i_ale_valid) begin
                {i_A_R, i_A_G, i_A_B} = {8'd10, 8'd10, 8'd10};
                pulsed = 1;
            end
            i_pix_valid = $urandom_range(0, 99) < pct;
            i_trans_valid = k >= tdel && $urandom_range(0, 99) < pct;
            {i_I_R, i_I_G, i_I_B, i_trans} = {r[pi], g[pi], b[pi], t[pi]};
            #1;
            hp = i_pix_valid & o_pix_ready;
            ht = i_trans_valid & o_trans_ready;
            if (k < tdel) chk("ready_before_trans", o_pix_ready, 0);
            if (tdel > 0 && k == tdel) chk("ready_on_trans", o_pix_ready, 1);
            chk("join", hp, ht);
            @(posedge clk);
            #1;
            chk("dp_valid", dp_valid, hp & ht);
            if (hp & ht) begin
                chk("dp_pix", {dp_I_R, dp_I_G, dp_I_B, dp_trans}, {r[pi], g[pi], b[pi], t[pi]});
                if (fire_cyc < 0) fire_cyc = cyc;
                pi++;
            end
            k++;
        end
        @(negedge clk);
        i_pix_valid = 0; i_trans_valid = 0; i_ale_valid = 0;
        chk("fires", pi, maxf);
    endtask

    task automatic wait_done();
        frames++;
        for (int k = 0; k < 200 && done_cnt < frames; k++) begin
            @(negedge clk);
            #1;
        end
        chk("frame_done", done_cnt, frames);
        repeat (3) @(negedge clk);
        chk("frame_done_once", done_cnt, frames);
        chk("queue_drained", expq.size(), 0);
        chk("no_err", o_err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [7:0] ar, ag, ab;
        rst = 1;
        {i_ale_valid, i_pix_valid, i_trans_valid, spur} = '0;
        {i_A_R, i_A_G, i_A_B, i_I_R, i_I_G, i_I_B, i_trans} = '0;
        repeat (3) @(negedge clk);
        rst_checks("reset");
        rst = 0;
        @(negedge clk);
        chk("idle_not_busy", o_busy, 0);

        // Basic 4x2 frame, streams always valid, sink always ready.
        lat_arm = 1;
        fire_cyc = -1;
        ale(8'd200, 8'd180, 8'd160);
        run_frame(8'd200, 8'd180, 8'd160, 100, 0, -1, NPIX, 60);
        wait_done();
        chk("latency", ov_cyc - fire_cyc, 4);

        // Sink stalled: a whole frame of credits issues, then nothing more.
        rdy_fixed = 0;
        {ar, ag, ab} = {8'($urandom), 8'($urandom), 8'($urandom)};
        ale(ar, ag, ab);
        run_frame(ar, ag, ab, 100, 0, -1, NPIX, 40);
        i_pix_valid = 1;
        i_trans_valid = 1;
        repeat (4) begin
            @(negedge clk);
            #1;
            chk("stalled_readies", {o_pix_ready, o_trans_ready, dp_valid}, 0);
            chk("stalled_valid", o_valid, 1);
        end
        i_pix_valid = 0;
        i_trans_valid = 0;
        rdy_fixed = 1;
        wait_done();

        // Transmission arrives 5 cycles after the pixel.
        {ar, ag, ab} = {8'($urandom), 8'($urandom), 8'($urandom)};
        ale(ar, ag, ab);
        run_frame(ar, ag, ab, 100, 5, -1, NPIX, 60);
        wait_done();

        // New A mid-frame: current frame keeps old A, next frame starts from the shadow.
        {ar, ag, ab} = {8'($urandom), 8'($urandom), 8'($urandom)};
        ale(ar, ag, ab);
        run_frame(ar, ag, ab, 100, 0, 3, NPIX, 60);
        frames++;
        for (int k = 0; k < 60 && done_cnt < frames; k++) begin
            @(negedge clk);
            #1;
        end
        chk("pend_frame_done", done_cnt, frames);
        @(negedge clk);
        #1;
        chk("pend_ale_pulse", dp_ale_valid, 1);
        chk("pend_value", {dp_A_R, dp_A_G, dp_A_B}, {8'd10, 8'd10, 8'd10});
        chk("pend_busy", o_busy, 1);
        run_frame(8'd10, 8'd10, 8'd10, 100, 0, -1, NPIX, 60);
        wait_done();

        // Random valids and random backpressure.
        rr_en = 1;
        repeat (2) begin
            {ar, ag, ab} = {8'($urandom), 8'($urandom), 8'($urandom)};
            ale(ar, ag, ab);
            run_frame(ar, ag, ab, 60, 0, -1, NPIX, 200);
            wait_done();
        end
        rr_en = 0;

        // Spurious result beat from the datapath.
        mon_en = 0;
        @(negedge clk);
        spur = 1;
        @(negedge clk);
        spur = 0;
        repeat (2) @(negedge clk);
        chk("err_set", o_err, 1);
        repeat (5) @(negedge clk);
        chk("err_sticky", o_err, 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("err_cleared", o_err, 0);
        mon_en = 1;

        // Reset after 3 beats, then a fresh frame with full credit.
        {ar, ag, ab} = {8'($urandom), 8'($urandom), 8'($urandom)};
        ale(ar, ag, ab);
        run_frame(ar, ag, ab, 100, 0, -1, 3, 60);
        @(negedge clk);
        mon_en = 0;
        rst = 1;
        #1;
        expq.delete();
        rst_checks("midframe_reset");
        @(negedge clk);
        rst = 0;
        mon_en = 1;
        rdy_fixed = 0;
        {ar, ag, ab} = {8'($urandom), 8'($urandom), 8'($urandom)};
        ale(ar, ag, ab);
        run_frame(ar, ag, ab, 100, 0, -1, NPIX, 40);
        rdy_fixed = 1;
        wait_done();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
